// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first.
// A start/busy/done handshake wraps the WIDTH-cycle addition.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One spare counter bit so out-of-range codes exist and can be trapped.
  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAdd  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] res_shift;

  // Single full-adder slice on the operand LSBs and the running carry.
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  end

  // Shift forms written without part-selects so WIDTH=1 stays legal.
  always_comb begin
    a_shift              = a_q >> 1;
    b_shift              = b_q >> 1;
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fa_sum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end

      StAdd: begin
        if (cnt_q > LastCnt) begin
          state_d = StIdle;
        end else begin
          a_d     = a_shift;
          b_d     = b_shift;
          res_d   = res_shift;
          carry_d = fa_carry;
          cnt_d   = cnt_q + CntW'(1);
          // Result registers only move on the final bit.
          if (cnt_q == LastCnt) begin
            sum_d   = res_shift;
            cout_d  = fa_carry;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StAdd);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: one WIDTH=8 and one WIDTH=1 instance on a shared clock/reset.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  logic       sel1;
  logic       cur_busy, cur_done;
  logic [8:0] cur_res;

  int         n_total;
  int         n_bad;
  logic [8:0] last8;
  logic [8:0] last1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur_busy = sel1 ? busy1 : busy8;
  assign cur_done = sel1 ? done1 : done8;
  assign cur_res  = sel1 ? {7'b0, cout1, sum1} : {cout8, sum8};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Starts one addition at the current negedge and follows it through the done pulse.
  // With hold set, start stays high and operands change while the add is running.
  task automatic do_add(input bit w1, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input bit hold);
    logic [8:0] exp;
    logic [8:0] prev;
    int         w;
    int         cyc;
    int         busy_n;
    sel1 = w1;
    if (w1) begin
      w      = 1;
      exp    = 9'(ta[0]) + 9'(tb[0]) + 9'(tc);
      prev   = last1;
      a1     = ta[0];
      b1     = tb[0];
      cin1   = tc;
      start1 = 1'b1;
    end else begin
      w      = 8;
      exp    = 9'(ta) + 9'(tb) + 9'(tc);
      prev   = last8;
      a8     = ta;
      b8     = tb;
      cin8   = tc;
      start8 = 1'b1;
    end
    @(negedge clk);
    if (hold) begin
      a8 = 8'h11;
      b8 = 8'h11;
      a1 = 1'b1;
      b1 = 1'b1;
    end else begin
      start8 = 1'b0;
      start1 = 1'b0;
    end
    cyc    = 1;
    busy_n = 0;
    while (!cur_done && cyc < 40) begin
      if (cur_busy) busy_n++;
      if (cyc == w) check("sum_held_during_add", 64'(cur_res), 64'(prev));
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    start1 = 1'b0;
    check("done_latency", 64'(cyc), 64'(w + 1));
    check("busy_cycles", 64'(busy_n), 64'(w));
    check("busy_low_at_done", 64'(cur_busy), 64'd0);
    check("result", 64'(cur_res), 64'(exp));
    if (w1) last1 = exp;
    else    last8 = exp;
    @(negedge clk);
    check("done_one_cycle", 64'(cur_done), 64'd0);
  endtask

  initial begin
    int         extra;
    logic [7:0] ra, rb;
    logic       rc;
    logic [2:0] combo;

    n_total = 0;
    n_bad   = 0;
    last8   = '0;
    last1   = '0;
    sel1    = 1'b0;
    rst_n   = 1'b0;
    {start8, a8, b8, cin8} = '0;
    {start1, a1, b1, cin1} = '0;

    repeat (3) @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_res8", 64'({cout8, sum8}), 64'd0);
    check("rst_res1", 64'({busy1, done1, cout1, sum1}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero operands, then carry out of the top bit, then a plain add.
    do_add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_add(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("idle_hold_result", 64'({cout8, sum8}), 64'h100);
    do_add(1'b0, 8'h3C, 8'h42, 1'b0, 1'b0);

    // Operands and start disturbed while the add is running.
    do_add(1'b0, 8'hA5, 8'h5A, 1'b1, 1'b1);
    extra = 0;
    repeat (12) begin
      if (done8 || busy8) extra++;
      @(negedge clk);
    end
    check("no_second_op", 64'(extra), 64'd0);

    // Asynchronous reset three cycles into an add.
    a8 = 8'h7F; b8 = 8'h7F; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(busy8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy8), 64'd0);
    check("async_rst_done", 64'(done8), 64'd0);
    check("async_rst_res", 64'({cout8, sum8}), 64'd0);
    last8 = '0;
    last1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 64'({busy8, done8}), 64'd0);
    do_add(1'b0, 8'h01, 8'h02, 1'b0, 1'b0);

    // WIDTH=1 truth table in order 000..111.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      do_add(1'b1, {7'b0, combo[2]}, {7'b0, combo[1]}, combo[0], 1'b0);
    end

    // Back-to-back random operands.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      do_add(1'b0, ra, rb, rc, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
